// File: rtl/consec_rep_checker_if.sv
// Bundle of signals between a stimulus source and the consecutive-repetition
// checker. The checker side takes the trigger/condition inputs and returns
// the attempt status, pulses and statistics counters.
interface consec_rep_checker_if #(
    parameter int unsigned CW = 16
) ();
    // Stimulus side of the property
    logic          en;
    logic          d;
    logic          a;
    logic          b;

    // Checker results
    logic          busy;
    logic          pass;
    logic          fail;
    logic [7:0]    rep_len;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic [CW-1:0] drop_cnt;

    // Source of en/d/a/b, observer of the results
    modport master (
        output en, d, a, b,
        input  busy, pass, fail, rep_len, pass_cnt, fail_cnt, drop_cnt
    );

    // The checker itself
    modport slave (
        input  en, d, a, b,
        output busy, pass, fail, rep_len, pass_cnt, fail_cnt, drop_cnt
    );
endinterface

// File: rtl/consec_rep_checker.sv
// Checks "d |-> a[*MIN_REP:MAX_REP] ##1 b" with overlapping implication.
// One attempt at a time: a trigger seen while an attempt runs is counted as
// dropped. pass/fail are registered one-cycle pulses; rep_len reports the
// run length of the last completed attempt. All counters saturate.
module consec_rep_checker #(
    parameter int unsigned MIN_REP = 1,
    parameter int unsigned MAX_REP = 0,
    parameter int unsigned CW      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    consec_rep_checker_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] MIN_C     = 8'(MIN_REP);
    localparam logic [7:0] MAX_C     = 8'(MAX_REP);
    localparam bit         UNBOUNDED = (MAX_REP == 0);

    state_t        state_q,    state_d;
    logic [7:0]    cnt_q,      cnt_d;
    logic          pass_q,     pass_d;
    logic          fail_q,     fail_d;
    logic [7:0]    rep_len_q,  rep_len_d;
    logic [CW-1:0] pass_cnt_q, pass_cnt_d;
    logic [CW-1:0] fail_cnt_q, fail_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    // Decision terms evaluated while an attempt is running
    logic          min_met;
    logic          may_extend;

    // Increment that holds at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Increment that holds at all-ones instead of wrapping
    function automatic logic [CW-1:0] sat_inc_cw(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // The run may end in a pass once MIN_REP a-cycles have been seen, and may
    // only keep growing while the MAX_REP bound (if any) is not yet reached.
    always_comb begin
        min_met    = (cnt_q >= MIN_C);
        may_extend = UNBOUNDED || (cnt_q < MAX_C);
    end

    // Next-state and next-output decision for the attempt FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        rep_len_d  = rep_len_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.en && bus.d) begin
                    if (bus.a) begin
                        // a is sampled together with d, so the run starts at 1
                        cnt_d   = 8'd1;
                        state_d = RUN;
                    end else begin
                        // Antecedent without a single a: immediate failure
                        fail_d     = 1'b1;
                        rep_len_d  = 8'd0;
                        fail_cnt_d = sat_inc_cw(fail_cnt_q);
                    end
                end
            end

            RUN: begin
                // Overlapping attempts are not tracked; count and discard the
                // trigger, independent of en, including on the deciding cycle.
                if (bus.d) begin
                    drop_cnt_d = sat_inc_cw(drop_cnt_q);
                end

                if (bus.b && min_met) begin
                    // First match wins: b ends the run even if a is also high
                    pass_d     = 1'b1;
                    rep_len_d  = cnt_q;
                    pass_cnt_d = sat_inc_cw(pass_cnt_q);
                    cnt_d      = 8'd0;
                    state_d    = IDLE;
                end else if (bus.a && may_extend) begin
                    cnt_d = sat_inc8(cnt_q);
                end else begin
                    // a dropped early, b came too soon, or the run hit MAX_REP
                    fail_d     = 1'b1;
                    rep_len_d  = cnt_q;
                    fail_cnt_d = sat_inc_cw(fail_cnt_q);
                    cnt_d      = 8'd0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State, pulses and statistics register bank; reset clears everything and
    // therefore aborts a running attempt without emitting a pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            rep_len_q  <= 8'd0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            rep_len_q  <= rep_len_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Outputs come straight from registers
    assign bus.busy     = (state_q == RUN);
    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;
    assign bus.rep_len  = rep_len_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.fail_cnt = fail_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_consec_rep_checker.sv
// Scoreboard bench for consec_rep_checker. Two instances share one stimulus
// stream: defaults (MIN 1, MAX unbounded, CW 16) and MIN 3, MAX 4, CW 4.
// The expected pulses are derived by scanning the stimulus from each accepted
// trigger forward and applying the property rules directly.
module tb_consec_rep_checker;

    localparam int NMAX = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    consec_rep_checker_if #(.CW(16)) bus0 ();
    consec_rep_checker_if #(.CW(4))  bus1 ();

    consec_rep_checker #(.MIN_REP(1), .MAX_REP(0), .CW(16)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    consec_rep_checker #(.MIN_REP(3), .MAX_REP(4), .CW(4)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        int t;
        bit is_pass;
        int len;
        int pc;
        int fc;
        int dc;
    } ev_t;

    bit   en_v [NMAX];
    bit   d_v  [NMAX];
    bit   a_v  [NMAX];
    bit   b_v  [NMAX];
    bit   rst_v[NMAX];
    int   n = 0;
    bit   bz [2][NMAX];
    ev_t  q0[$];
    ev_t  q1[$];
    int   fin_pc[2];
    int   fin_fc[2];
    int   fin_dc[2];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   started = 1'b0;
    int   mon_t = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic put(input bit en, input bit d, input bit a, input bit b, input bit rn);
        if (n < NMAX) begin
            en_v[n] = en; d_v[n] = d; a_v[n] = a; b_v[n] = b; rst_v[n] = rn;
            n++;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) put(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_ev(input int id, input int t, input bit p, input int len,
                           input int pc, input int fc, input int dc);
        ev_t e;
        e.t = t; e.is_pass = p; e.len = len; e.pc = pc; e.fc = fc; e.dc = dc;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Reference: for every accepted trigger, walk forward until the property
    // is decided (or reset / end of stimulus intervenes).
    task automatic run_model(input int id, input int mn, input int mx, input int cap);
        int  pc, fc, dc, t, j, u, c;
        bit  done;
        pc = 0; fc = 0; dc = 0; t = 0;
        while (t < n) begin
            if (!rst_v[t]) begin
                pc = 0; fc = 0; dc = 0;
                t++;
            end else if (en_v[t] && d_v[t] && !a_v[t]) begin
                if (fc < cap) fc++;
                push_ev(id, t, 1'b0, 0, pc, fc, dc);
                t++;
            end else if (en_v[t] && d_v[t]) begin
                bz[id][t] = 1'b1;
                j = 1;
                done = 1'b0;
                while (!done) begin
                    u = t + j;
                    c = (j > 255) ? 255 : j;
                    if (u >= n) begin
                        done = 1'b1; t = n;
                    end else if (!rst_v[u]) begin
                        done = 1'b1; t = u;
                    end else begin
                        if (d_v[u] && dc < cap) dc++;
                        if (b_v[u] && c >= mn) begin
                            if (pc < cap) pc++;
                            push_ev(id, u, 1'b1, c, pc, fc, dc);
                            done = 1'b1; t = u + 1;
                        end else if (a_v[u] && (mx == 0 || c < mx)) begin
                            bz[id][u] = 1'b1;
                            j++;
                        end else begin
                            if (fc < cap) fc++;
                            push_ev(id, u, 1'b0, c, pc, fc, dc);
                            done = 1'b1; t = u + 1;
                        end
                    end
                end
            end else begin
                t++;
            end
        end
        fin_pc[id] = pc; fin_fc[id] = fc; fin_dc[id] = dc;
    endtask

    task automatic check_dut(input int id, input int t, input int busy, input int pass,
                             input int fail, input int rl, input int pc, input int fc,
                             input int dc);
        ev_t e;
        bit  expp;
        string tag;
        tag = $sformatf("dut%0d@%0d", id, t);
        cmp({"busy ", tag}, busy, int'(bz[id][t]));
        cmp({"pass_fail_exclusive ", tag}, pass & fail, 0);
        if (!rst_v[t]) cmp({"reset_state ", tag}, busy + pass + fail + rl + pc + fc + dc, 0);
        if (id == 0) expp = (q0.size() > 0 && q0[0].t == t);
        else         expp = (q1.size() > 0 && q1[0].t == t);
        cmp({"pulse ", tag}, pass | fail, int'(expp));
        if (expp) begin
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            if (pass | fail) begin
                cmp({"kind_pass ", tag}, pass, int'(e.is_pass));
                cmp({"rep_len ", tag}, rl, e.len);
                cmp({"pass_cnt ", tag}, pc, e.pc);
                cmp({"fail_cnt ", tag}, fc, e.fc);
                cmp({"drop_cnt ", tag}, dc, e.dc);
            end
        end
        if (t == n - 1) begin
            cmp({"final_pass_cnt ", tag}, pc, fin_pc[id]);
            cmp({"final_fail_cnt ", tag}, fc, fin_fc[id]);
            cmp({"final_drop_cnt ", tag}, dc, fin_dc[id]);
        end
    endtask

    // Monitor: one slot per clock edge, sampled 1 time unit after the edge
    always @(posedge clk) begin
        if (started && mon_t < n) begin
            #1;
            check_dut(0, mon_t, int'(bus0.busy), int'(bus0.pass), int'(bus0.fail),
                      int'(bus0.rep_len), int'(bus0.pass_cnt), int'(bus0.fail_cnt),
                      int'(bus0.drop_cnt));
            check_dut(1, mon_t, int'(bus1.busy), int'(bus1.pass), int'(bus1.fail),
                      int'(bus1.rep_len), int'(bus1.pass_cnt), int'(bus1.fail_cnt),
                      int'(bus1.drop_cnt));
            mon_t++;
        end
    end

    // Stimulus: build the whole stream, derive expectations, then drive it
    initial begin
        bus0.en = 0; bus0.d = 0; bus0.a = 0; bus0.b = 0;
        bus1.en = 0; bus1.d = 0; bus1.a = 0; bus1.b = 0;

        // Reset with a trigger present (ignored), then first attempt right away
        put(1, 1, 1, 0, 0); put(1, 1, 1, 0, 0);
        put(1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) put(1, 0, 1, 0, 1);
        put(1, 0, 0, 1, 1);
        idle(3);
        // Immediate fail, then a run of one ended by a=0,b=0
        put(1, 1, 0, 0, 1); idle(2);
        put(1, 1, 1, 0, 1); put(1, 0, 0, 0, 1); idle(2);
        // Runs of 2, 3 and 4 for the bounded instance
        put(1, 1, 1, 0, 1); put(1, 0, 1, 0, 1); put(1, 0, 0, 1, 1); idle(2);
        put(1, 1, 1, 0, 1); put(1, 0, 1, 0, 1); put(1, 0, 1, 0, 1); put(1, 0, 0, 1, 1); idle(2);
        put(1, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) put(1, 0, 1, 0, 1);
        put(1, 0, 1, 0, 1); put(1, 0, 0, 0, 1); idle(2);
        // Two dropped triggers, then a new attempt in the pass-pulse cycle
        put(1, 1, 1, 0, 1); put(1, 1, 1, 0, 1); put(1, 0, 1, 0, 1); put(1, 1, 1, 0, 1);
        put(1, 0, 0, 1, 1); put(1, 1, 1, 0, 1); put(1, 0, 0, 1, 1); idle(2);
        // en=0: trigger ignored in IDLE, running attempt still completes
        put(0, 1, 0, 0, 1); put(1, 1, 1, 0, 1); put(0, 0, 1, 0, 1); put(0, 1, 0, 1, 1); idle(2);
        // Reset in the middle of a run at cnt=3
        put(1, 1, 1, 0, 1); put(1, 0, 1, 0, 1); put(1, 0, 1, 0, 1); put(1, 0, 1, 0, 0); idle(2);
        // Twenty passing attempts: the CW=4 counter must stop at 15
        for (int i = 0; i < 20; i++) begin
            put(1, 1, 1, 0, 1); put(1, 0, 1, 0, 1); put(1, 0, 1, 0, 1); put(1, 0, 0, 1, 1);
        end
        idle(2);
        // Random traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            put($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 399) != 0);
        end

        run_model(0, 1, 0, 65535);
        run_model(1, 3, 4, 15);

        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            rst_n   = rst_v[t];
            bus0.en = en_v[t]; bus0.d = d_v[t]; bus0.a = a_v[t]; bus0.b = b_v[t];
            bus1.en = en_v[t]; bus1.d = d_v[t]; bus1.a = a_v[t]; bus1.b = b_v[t];
            started = 1'b1;
        end
        @(negedge clk);
        bus0.en = 0; bus0.d = 0; bus1.en = 0; bus1.d = 0;

        for (int k = 0; k < 20 && mon_t < n; k++) @(posedge clk);
        #2;
        cmp("monitor_reached_end", mon_t, n);
        cmp("pending_events", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
